// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Front-end control stage for the stopwatch digit counter chain.
// It conditions the raw buttons and the direction switch, runs the
// IDLE/RUN/PAUSE/DONE state machine, divides clk down to the count tick,
// and drives the digit chain's control inputs.
//
// Configuration macro: STOPWATCH_AUTOSTOP_EN
//   Defined   - a countdown that reaches zero on a tick stops in DONE.
//   Undefined - cnt_zero is ignored, DONE is unreachable, done is tied 0.
//
// Parameters
//   CLK_HZ          input clock frequency
//   TICK_HZ         count tick rate; DIV = CLK_HZ/TICK_HZ must be >= 2
//   DEBOUNCE_CYCLES consecutive stable samples to accept a level (>= 2)
//
// Ports
//   clk        system clock
//   clr        asynchronous active-high reset
//   btn_start  raw start/stop button (async)
//   btn_lap    raw lap button (async)
//   btn_reset  raw reset button (async)
//   sw_dir     direction switch, 1 = up, 0 = down (async)
//   cnt_zero   all counter digits are zero
//   cnt_en     one-cycle count strobe at TICK_HZ while running
//   dir        count direction to the digit chain
//   lap_press  lap request level to the digit chain
//   cnt_clr    one-cycle synchronous clear pulse to the digit chain
//   lap_hold   display frozen on the lap value
//   done       countdown finished
//   state      00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
module stopwatch_ctrl #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_reset,
    input  logic       sw_dir,
    input  logic       cnt_zero,
    output logic       cnt_en,
    output logic       dir,
    output logic       lap_press,
    output logic       cnt_clr,
    output logic       lap_hold,
    output logic       done,
    output logic [1:0] state
);

    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PW   = $clog2(DIV);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

`ifdef STOPWATCH_AUTOSTOP_EN
    localparam logic AUTOSTOP = 1'b1;
`else
    localparam logic AUTOSTOP = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } fsm_t;

    // Bit order of the conditioned inputs: {sw_dir, btn_reset, btn_lap, btn_start}
    logic [3:0]    raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    level;
    logic [DW-1:0] db_cnt [4];
    logic [2:0]    btn_prev;
    logic [2:0]    press;

    fsm_t          fsm;
    logic [PW-1:0] presc;
    logic          lap_q;
    logic          clr_q;
    logic          dir_q;

    logic start_ev;
    logic lap_ev;
    logic reset_ev;
    logic start_act;
    logic lap_act;
    logic tick_due;
    logic count_end;

    assign raw = {sw_dir, btn_reset, btn_lap, btn_start};

    // Two-flop synchronisers for every asynchronous input.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: count consecutive samples that disagree with the accepted
    // level; any agreeing sample restarts the count. The switch level resets
    // to 1 so dir does not dip to 0 right after reset while the switch is up.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            level    <= 4'b1000;
            btn_prev <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            btn_prev <= level[2:0];
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != level[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        level[i]  <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Press events are single-cycle pulses on a rising debounced level.
    // Priority reset > start > lap drops the lower events of a shared cycle.
    assign press     = level[2:0] & ~btn_prev;
    assign start_ev  = press[0];
    assign lap_ev    = press[1];
    assign reset_ev  = press[2];
    assign start_act = start_ev & ~reset_ev;
    assign lap_act   = lap_ev & ~start_ev & ~reset_ev;

    // A tick is due on the last prescaler count while running. A countdown
    // that is already at zero ends here instead of issuing that tick.
    assign tick_due  = (fsm == RUN) && (presc == DIV_LAST);
    assign count_end = AUTOSTOP & tick_due & ~dir_q & cnt_zero;

    // Main state machine together with prescaler, lap hold, clear pulse and
    // direction latch; dir only follows the switch while idle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            fsm   <= IDLE;
            presc <= '0;
            lap_q <= 1'b0;
            clr_q <= 1'b0;
            dir_q <= 1'b1;
        end else begin
            clr_q <= 1'b0;
            if (fsm == IDLE) begin
                dir_q <= level[3];
            end
            case (fsm)
                IDLE: begin
                    presc <= '0;
                    if (reset_ev) begin
                        clr_q <= 1'b1;
                    end else if (start_act) begin
                        fsm <= RUN;
                    end
                end
                RUN: begin
                    presc <= (presc == DIV_LAST) ? '0 : presc + 1'b1;
                    if (count_end) begin
                        fsm <= DONE;
                    end else if (start_act) begin
                        fsm <= PAUSE;
                    end else if (lap_act) begin
                        lap_q <= ~lap_q;
                    end
                end
                PAUSE: begin
                    if (reset_ev) begin
                        fsm   <= IDLE;
                        presc <= '0;
                        lap_q <= 1'b0;
                        clr_q <= 1'b1;
                    end else if (start_act) begin
                        fsm <= RUN;
                    end else if (lap_act) begin
                        lap_q <= 1'b0;
                    end
                end
                DONE: begin
                    if (reset_ev) begin
                        fsm   <= IDLE;
                        presc <= '0;
                        lap_q <= 1'b0;
                        clr_q <= 1'b1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign cnt_en    = tick_due & ~count_end;
    assign dir       = dir_q;
    assign lap_hold  = lap_q;
    assign lap_press = lap_q;
    assign cnt_clr   = clr_q;
    assign done      = AUTOSTOP & (fsm == DONE);
    assign state     = fsm;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
// Directed bench for stopwatch_ctrl with CLK_HZ=1000, TICK_HZ=100 (DIV=10)
// and DEBOUNCE_CYCLES=4. Each table row holds its inputs for n cycles,
// counts cnt_en/cnt_clr pulses seen at every falling edge, then checks the
// final state and levels. A button must be held 6 cycles for a press event
// and the state machine reacts one cycle after release.
module tb_stopwatch_ctrl;

    logic       clk;
    logic       clr;
    logic       btn_start;
    logic       btn_lap;
    logic       btn_reset;
    logic       sw_dir;
    logic       cnt_zero;
    logic       cnt_en;
    logic       dir;
    logic       lap_press;
    logic       cnt_clr;
    logic       lap_hold;
    logic       done;
    logic [1:0] state;

    int total;
    int bad;

    typedef struct {
        int         n;
        logic       st;
        logic       lp;
        logic       rs;
        logic       sw;
        logic       cz;
        logic [1:0] exp_state;
        logic       exp_lap;
        logic       exp_dir;
        logic       exp_done;
        int         exp_ens;
        int         exp_clrs;
    } vec_t;

    vec_t vecs[$];

    localparam logic [1:0] SI = 2'b00;
    localparam logic [1:0] SR = 2'b01;
    localparam logic [1:0] SP = 2'b10;
    localparam logic [1:0] SD = 2'b11;

    stopwatch_ctrl #(
        .CLK_HZ         (1000),
        .TICK_HZ        (100),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .btn_start(btn_start),
        .btn_lap  (btn_lap),
        .btn_reset(btn_reset),
        .sw_dir   (sw_dir),
        .cnt_zero (cnt_zero),
        .cnt_en   (cnt_en),
        .dir      (dir),
        .lap_press(lap_press),
        .cnt_clr  (cnt_clr),
        .lap_hold (lap_hold),
        .done     (done),
        .state    (state)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input int row, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s row %0d: got %0d expected %0d", name, row, actual, expected);
        end
    endtask

    task automatic add_vec(input int n, input logic st, input logic lp, input logic rs,
                           input logic sw, input logic cz, input logic [1:0] es,
                           input logic el, input logic ed, input logic edn,
                           input int ens, input int clrs);
        vec_t v;
        v.n = n; v.st = st; v.lp = lp; v.rs = rs; v.sw = sw; v.cz = cz;
        v.exp_state = es; v.exp_lap = el; v.exp_dir = ed; v.exp_done = edn;
        v.exp_ens = ens; v.exp_clrs = clrs;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input vec_t v);
        btn_start = v.st;
        btn_lap   = v.lp;
        btn_reset = v.rs;
        sw_dir    = v.sw;
        cnt_zero  = v.cz;
    endtask

    initial begin
        int ens;
        int clrs;
        int overlap;
        int waited;
        total = 0;
        bad   = 0;
        overlap = 0;

        // n, st, lp, rs, sw, cz, state, lap, dir, done, ens, clrs
        add_vec( 3, 1, 0, 0, 1, 0, SI, 0, 1, 0, 0, 0);  // 3-cycle glitch
        add_vec( 8, 0, 0, 0, 1, 0, SI, 0, 1, 0, 0, 0);
        add_vec( 6, 1, 0, 0, 1, 0, SI, 0, 1, 0, 0, 0);  // real start press
        add_vec( 1, 0, 0, 0, 1, 0, SR, 0, 1, 0, 0, 0);  // RUN, prescaler 0
        add_vec( 8, 0, 0, 0, 1, 0, SR, 0, 1, 0, 0, 0);
        add_vec( 1, 0, 0, 0, 1, 0, SR, 0, 1, 0, 1, 0);  // first tick
        add_vec(10, 0, 0, 0, 1, 0, SR, 0, 1, 0, 1, 0);
        add_vec( 9, 0, 0, 0, 1, 0, SR, 0, 1, 0, 0, 0);
        add_vec( 6, 1, 0, 0, 1, 0, SR, 0, 1, 0, 1, 0);  // event at prescaler 4
        add_vec( 1, 0, 0, 0, 1, 0, SP, 0, 1, 0, 0, 0);
        add_vec(10, 0, 0, 0, 1, 0, SP, 0, 1, 0, 0, 0);
        add_vec( 6, 1, 0, 0, 1, 0, SP, 0, 1, 0, 0, 0);
        add_vec( 1, 0, 0, 0, 1, 0, SR, 0, 1, 0, 0, 0);  // resume at prescaler 5
        add_vec( 3, 0, 0, 0, 1, 0, SR, 0, 1, 0, 0, 0);
        add_vec( 1, 0, 0, 0, 1, 0, SR, 0, 1, 0, 1, 0);
        add_vec( 6, 0, 1, 0, 1, 0, SR, 0, 1, 0, 0, 0);  // lap press
        add_vec( 1, 0, 0, 0, 1, 0, SR, 1, 1, 0, 0, 0);
        add_vec( 3, 0, 0, 0, 1, 0, SR, 1, 1, 0, 1, 0);
        add_vec( 4, 0, 0, 0, 1, 0, SR, 1, 1, 0, 0, 0);
        add_vec( 6, 0, 1, 0, 1, 0, SR, 1, 1, 0, 1, 0);  // second lap
        add_vec( 1, 0, 0, 0, 1, 0, SR, 0, 1, 0, 0, 0);
        add_vec( 7, 0, 0, 0, 1, 0, SR, 0, 1, 0, 0, 0);
        add_vec( 6, 0, 1, 0, 1, 0, SR, 0, 1, 0, 1, 0);
        add_vec( 1, 0, 0, 0, 1, 0, SR, 1, 1, 0, 0, 0);
        add_vec( 7, 0, 0, 0, 1, 0, SR, 1, 1, 0, 1, 0);
        add_vec( 6, 1, 1, 0, 1, 0, SR, 1, 1, 0, 0, 0);  // start + lap together
        add_vec( 1, 0, 0, 0, 1, 0, SP, 1, 1, 0, 0, 0);
        add_vec( 7, 0, 0, 0, 1, 0, SP, 1, 1, 0, 0, 0);
        add_vec( 6, 0, 0, 1, 1, 0, SP, 1, 1, 0, 0, 0);  // reset from PAUSE
        add_vec( 1, 0, 0, 0, 1, 0, SI, 0, 1, 0, 0, 1);
        add_vec( 3, 0, 0, 0, 1, 0, SI, 0, 1, 0, 0, 0);
        add_vec( 6, 1, 0, 0, 1, 0, SI, 0, 1, 0, 0, 0);
        add_vec( 1, 0, 0, 0, 1, 0, SR, 0, 1, 0, 0, 0);
        add_vec( 7, 0, 0, 0, 1, 0, SR, 0, 1, 0, 0, 0);
        add_vec( 6, 0, 0, 1, 1, 0, SR, 0, 1, 0, 1, 0);  // reset in RUN ignored
        add_vec( 1, 0, 0, 0, 1, 0, SR, 0, 1, 0, 0, 0);
        add_vec( 5, 0, 0, 0, 1, 0, SR, 0, 1, 0, 1, 0);
        add_vec( 6, 1, 0, 0, 1, 0, SR, 0, 1, 0, 0, 0);
        add_vec( 1, 0, 0, 0, 1, 0, SP, 0, 1, 0, 0, 0);
        add_vec( 7, 0, 0, 0, 1, 0, SP, 0, 1, 0, 0, 0);
        add_vec( 6, 0, 0, 1, 1, 0, SP, 0, 1, 0, 0, 0);
        add_vec( 1, 0, 0, 0, 1, 0, SI, 0, 1, 0, 0, 1);
        add_vec( 8, 0, 0, 0, 0, 0, SI, 0, 0, 0, 0, 0);  // switch to down
        add_vec( 6, 1, 0, 0, 0, 0, SI, 0, 0, 0, 0, 0);
        add_vec( 1, 0, 0, 0, 0, 0, SR, 0, 0, 0, 0, 0);
        add_vec( 8, 0, 0, 0, 1, 0, SR, 0, 0, 0, 0, 0);  // dir held in RUN
`ifdef STOPWATCH_AUTOSTOP_EN
        add_vec( 1, 0, 0, 0, 1, 1, SR, 0, 0, 0, 0, 0);  // tick suppressed
        add_vec( 1, 0, 0, 0, 1, 1, SD, 0, 0, 1, 0, 0);
        add_vec( 7, 0, 0, 0, 1, 0, SD, 0, 0, 1, 0, 0);
        add_vec( 6, 1, 0, 0, 1, 0, SD, 0, 0, 1, 0, 0);  // start ignored
        add_vec( 1, 0, 0, 0, 1, 0, SD, 0, 0, 1, 0, 0);
        add_vec( 5, 0, 0, 0, 1, 0, SD, 0, 0, 1, 0, 0);
        add_vec( 6, 0, 0, 1, 1, 0, SD, 0, 0, 1, 0, 0);
        add_vec( 1, 0, 0, 0, 1, 0, SI, 0, 0, 0, 0, 1);
        add_vec( 2, 0, 0, 0, 1, 0, SI, 0, 1, 0, 0, 0);
`else
        add_vec( 1, 0, 0, 0, 1, 1, SR, 0, 0, 0, 1, 0);  // keeps ticking
        add_vec( 1, 0, 0, 0, 1, 1, SR, 0, 0, 0, 0, 0);
        add_vec( 7, 0, 0, 0, 1, 0, SR, 0, 0, 0, 0, 0);
        add_vec( 6, 1, 0, 0, 1, 0, SR, 0, 0, 0, 1, 0);
        add_vec( 1, 0, 0, 0, 1, 0, SP, 0, 0, 0, 0, 0);
        add_vec( 5, 0, 0, 0, 1, 0, SP, 0, 0, 0, 0, 0);
        add_vec( 6, 0, 0, 1, 1, 0, SP, 0, 0, 0, 0, 0);
        add_vec( 1, 0, 0, 0, 1, 0, SI, 0, 0, 0, 0, 1);
        add_vec( 2, 0, 0, 0, 1, 0, SI, 0, 1, 0, 0, 0);
`endif

        // Reset state while clr is held.
        clr = 1'b1;
        btn_start = 1'b0; btn_lap = 1'b0; btn_reset = 1'b0;
        sw_dir = 1'b1; cnt_zero = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_state",   -1, int'(state),     0);
        check_output("rst_dir",     -1, int'(dir),       1);
        check_output("rst_cnt_en",  -1, int'(cnt_en),    0);
        check_output("rst_cnt_clr", -1, int'(cnt_clr),   0);
        check_output("rst_lap",     -1, int'(lap_press), 0);
        check_output("rst_done",    -1, int'(done),      0);
        clr = 1'b0;

        foreach (vecs[r]) begin
            apply_stimulus(vecs[r]);
            ens  = 0;
            clrs = 0;
            for (int c = 0; c < vecs[r].n; c++) begin
                @(negedge clk);
                ens  += int'(cnt_en);
                clrs += int'(cnt_clr);
                if (cnt_en && cnt_clr) overlap++;
            end
            check_output("state",     r, int'(state),     int'(vecs[r].exp_state));
            check_output("lap_hold",  r, int'(lap_hold),  int'(vecs[r].exp_lap));
            check_output("lap_press", r, int'(lap_press), int'(vecs[r].exp_lap));
            check_output("dir",       r, int'(dir),       int'(vecs[r].exp_dir));
            check_output("done",      r, int'(done),      int'(vecs[r].exp_done));
            check_output("en_pulses", r, ens,             vecs[r].exp_ens);
            check_output("clr_pulses",r, clrs,            vecs[r].exp_clrs);
        end
        check_output("en_clr_overlap", -1, overlap, 0);

        // Asynchronous clr in the middle of a run: immediate return to the
        // reset state with no clear pulse.
        btn_start = 1'b1;
        repeat (6) @(negedge clk);
        btn_start = 1'b0;
        waited = 0;
        while (state != SR && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_output("midclr_run", -2, int'(state), int'(SR));
        repeat (3) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check_output("midclr_state",  -2, int'(state),     0);
        check_output("midclr_cnt_en", -2, int'(cnt_en),    0);
        check_output("midclr_cnt_clr",-2, int'(cnt_clr),   0);
        check_output("midclr_dir",    -2, int'(dir),       1);
        @(negedge clk);
        clr = 1'b0;
        clrs = 0;
        repeat (3) begin
            @(negedge clk);
            clrs += int'(cnt_clr);
        end
        check_output("midclr_no_pulse", -2, clrs,        0);
        check_output("midclr_idle",     -2, int'(state), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
